cache_arbiter: RTL and testbench

- Shares one lower-level memory port between the instruction-cache miss path and the data-cache miss/writeback path.
- Sits between the two L1 caches that serve the cpu's cmem_*_a (fetch) and cmem_*_b (load/store) ports and the single physical memory.
- Runs one line-sized transaction at a time.
- Grants round-robin between the two requesters; on the first contention after reset, data wins.

---
 rtl/cache_arbiter.sv | 106 ++++++++++
 tb/tb_cache_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one line-sized memory port between the I-cache fill
// path and the D-cache fill/writeback path. One transaction is in flight at
// a time. Contention is settled round-robin, and data wins the first tie
// after reset.
//
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   i_read / i_address     I-side fill request, held until i_resp
//   i_resp / i_rdata       I-side completion pulse and fill data
//   d_read / d_write       D-side fill or writeback request, held until d_resp
//   d_address / d_wdata    D-side line address and writeback data
//   d_resp / d_rdata       D-side completion pulse and fill data
//   mem_read / mem_write   registered memory strobes, held until mem_resp
//   mem_address/mem_wdata  address and write data latched at grant
//   mem_resp / mem_rdata   memory completion pulse and read data
module cache_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp,
  input  logic [LINE_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } state_t;

  state_t state;
  logic   last_grant;  // 0 = I served last, 1 = D served last
  logic   d_req;
  logic   grant_d;

  // D wins when it is the only requester, or on a tie when I was served last.
  always_comb begin
    d_req   = d_read | d_write;
    grant_d = d_req & (~i_read | ~last_grant);
  end

  // Fill data goes straight through; only the completion pulse is steered.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign i_resp  = (state == SERVE_I) & mem_resp;
  assign d_resp  = (state == SERVE_D) & mem_resp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state       <= SERVE_D;
            last_grant  <= 1'b1;
            mem_address <= d_address;
            mem_wdata   <= d_wdata;
            // A writeback takes priority over a fill raised at the same time.
            mem_write   <= d_write;
            mem_read    <= ~d_write;
          end else if (i_read) begin
            state       <= SERVE_I;
            last_grant  <= 1'b0;
            mem_address <= i_address;
            mem_read    <= 1'b1;
            mem_write   <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed bench for cache_arbiter. Inputs are driven 1ns
// after the rising edge and outputs are checked on the falling edge.
module tb_cache_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic          clk;
  logic          reset;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic          i_resp;
  logic [LW-1:0] i_rdata;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic          d_resp;
  logic [LW-1:0] d_rdata;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic          mem_resp;
  logic [LW-1:0] mem_rdata;

  int compared = 0;
  int mismatched = 0;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge (start of a new cycle).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
    step();
    step();
    @(negedge clk);
    compared++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_strobes: got %b expected 0000", {mem_read, mem_write, i_resp, d_resp});
    end
    compared++;
    if (mem_address !== 32'h0 || mem_wdata !== '0) begin
      mismatched++;
      $display("FAIL reset_addr_data: got addr %h wdata %h expected zeros", mem_address, mem_wdata);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_i_only();
    logic [LW-1:0] a5;
    a5 = {32{8'hA5}};
    step();                                  // cycle 0
    i_read = 1'b1; i_address = 32'h0000_0040;
    step();                                  // cycle 1
    @(negedge clk);
    compared++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h40) begin
      mismatched++;
      $display("FAIL i_only_grant: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=00000040",
               mem_read, mem_write, mem_address);
    end
    step();                                  // cycle 2
    step();                                  // cycle 3
    @(negedge clk);
    compared++;
    if (i_resp !== 1'b0 || mem_read !== 1'b1) begin
      mismatched++;
      $display("FAIL i_only_wait: got i_resp=%b mem_read=%b expected 0/1", i_resp, mem_read);
    end
    step();                                  // cycle 4
    mem_resp = 1'b1; mem_rdata = a5;
    @(negedge clk);
    compared++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== a5) begin
      mismatched++;
      $display("FAIL i_only_resp: got i_resp=%b d_resp=%b i_rdata=%h expected 1/0/%h",
               i_resp, d_resp, i_rdata, a5);
    end
    step();                                  // cycle 5
    mem_resp = 1'b0; i_read = 1'b0;
    @(negedge clk);
    compared++;
    if (mem_read !== 1'b0 || i_resp !== 1'b0) begin
      mismatched++;
      $display("FAIL i_only_done: got mem_read=%b i_resp=%b expected 0/0", mem_read, i_resp);
    end
  endtask

  task automatic test_d_write();
    logic [LW-1:0] wd;
    wd = {8{32'h1234_5678}};
    step();
    // Fill and writeback raised together: the writeback must win.
    d_write = 1'b1; d_read = 1'b1; d_address = 32'h0000_1000; d_wdata = wd;
    step();
    @(negedge clk);
    compared++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h1000 || mem_wdata !== wd) begin
      mismatched++;
      $display("FAIL d_write_grant: got wr=%b rd=%b addr=%h wdata=%h expected 1/0/00001000/%h",
               mem_write, mem_read, mem_address, mem_wdata, wd);
    end
    step();
    step();
    @(negedge clk);
    compared++;
    if (d_resp !== 1'b0 || i_resp !== 1'b0) begin
      mismatched++;
      $display("FAIL d_write_noresp: got d_resp=%b i_resp=%b expected 0/0", d_resp, i_resp);
    end
    step();
    mem_resp = 1'b1; mem_rdata = '0;
    @(negedge clk);
    compared++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
      mismatched++;
      $display("FAIL d_write_resp: got d_resp=%b i_resp=%b expected 1/0", d_resp, i_resp);
    end
    step();
    mem_resp = 1'b0; d_write = 1'b0; d_read = 1'b0;
    @(negedge clk);
    compared++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
      mismatched++;
      $display("FAIL d_write_done: got wr=%b rd=%b expected 0/0", mem_write, mem_read);
    end
  endtask

  task automatic test_contention();
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_0080;
    d_read = 1'b1; d_address = 32'h0000_0100;
    step();
    @(negedge clk);
    compared++;
    if (mem_read !== 1'b1 || mem_address !== 32'h100) begin
      mismatched++;
      $display("FAIL contention_first_d: got rd=%b addr=%h expected 1/00000100", mem_read, mem_address);
    end
    step();
    mem_resp = 1'b1; mem_rdata = {64{4'h3}};
    @(negedge clk);
    compared++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
      mismatched++;
      $display("FAIL contention_d_resp: got d_resp=%b i_resp=%b expected 1/0", d_resp, i_resp);
    end
    step();                                  // idle cycle
    mem_resp = 1'b0; d_read = 1'b0;
    @(negedge clk);
    compared++;
    if (mem_read !== 1'b0) begin
      mismatched++;
      $display("FAIL contention_idle: got mem_read=%b expected 0", mem_read);
    end
    step();
    @(negedge clk);
    compared++;
    if (mem_read !== 1'b1 || mem_address !== 32'h80) begin
      mismatched++;
      $display("FAIL contention_then_i: got rd=%b addr=%h expected 1/00000080", mem_read, mem_address);
    end
    step();
    mem_resp = 1'b1;
    @(negedge clk);
    compared++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
      mismatched++;
      $display("FAIL contention_i_resp: got i_resp=%b d_resp=%b expected 1/0", i_resp, d_resp);
    end
    step();
    mem_resp = 1'b0; i_read = 1'b0;
  endtask

  task automatic test_sustained();
    logic [AW-1:0] exp_addr;
    logic          exp_d;
    logic [LW-1:0] rd;
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_0400;
    d_read = 1'b1; d_address = 32'h0000_0800;
    for (int t = 0; t < 4; t++) begin
      exp_d    = (t % 2 == 0);
      exp_addr = exp_d ? 32'h800 : 32'h400;
      rd       = {8{t[31:0] + 32'hC0DE_0000}};
      step();                                // strobe cycle
      @(negedge clk);
      compared++;
      if (mem_read !== 1'b1 || mem_address !== exp_addr) begin
        mismatched++;
        $display("FAIL sustained_grant[%0d]: got rd=%b addr=%h expected 1/%h", t, mem_read, mem_address, exp_addr);
      end
      step();                                // response cycle
      mem_resp = 1'b1; mem_rdata = rd;
      @(negedge clk);
      compared++;
      if (d_resp !== exp_d || i_resp !== !exp_d || (exp_d ? d_rdata : i_rdata) !== rd) begin
        mismatched++;
        $display("FAIL sustained_resp[%0d]: got d_resp=%b i_resp=%b expected %b/%b", t, d_resp, i_resp, exp_d, !exp_d);
      end
      step();                                // idle cycle, both still requesting
      mem_resp = 1'b0;
    end
    i_read = 1'b0; d_read = 1'b0;
    step();
  endtask

  task automatic test_input_instability();
    do_reset();
    d_read = 1'b1; d_address = 32'h0000_2000;
    step();
    @(negedge clk);
    d_address = 32'h0000_3000; i_read = 1'b1; i_address = 32'h0000_5000;
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      compared++;
      if (mem_address !== 32'h2000 || mem_read !== 1'b1 || d_resp !== 1'b0) begin
        mismatched++;
        $display("FAIL instability_hold[%0d]: got addr=%h rd=%b d_resp=%b expected 00002000/1/0",
                 c, mem_address, mem_read, d_resp);
      end
    end
    step();
    mem_resp = 1'b1;
    @(negedge clk);
    compared++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || mem_address !== 32'h2000) begin
      mismatched++;
      $display("FAIL instability_resp: got d_resp=%b i_resp=%b addr=%h expected 1/0/00002000",
               d_resp, i_resp, mem_address);
    end
    step();
    mem_resp = 1'b0; d_read = 1'b0; i_read = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_0040;
    step();                                  // SERVE_I strobe cycle
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; i_read = 1'b0;
    @(negedge clk);
    compared++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000 || mem_address !== 32'h0 || mem_wdata !== '0) begin
      mismatched++;
      $display("FAIL reset_mid_outputs: got rd=%b wr=%b ir=%b dr=%b addr=%h expected all zero",
               mem_read, mem_write, i_resp, d_resp, mem_address);
    end
    step();
    mem_resp = 1'b1;                         // stray late response
    @(negedge clk);
    compared++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0 || mem_read !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_stray: got i_resp=%b d_resp=%b rd=%b expected 0/0/0", i_resp, d_resp, mem_read);
    end
    step();
    mem_resp = 1'b0;
    @(negedge clk);
    compared++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_idle: got rd=%b wr=%b expected 0/0", mem_read, mem_write);
    end
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_d_write();
    test_contention();
    test_sustained();
    test_input_instability();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
